// File: rtl/can_bit_timing_pkg.sv
// -----------------------------------------------------------------------------
// can_pkg
// Shared CAN bit-timing definitions: segment encoding, bus level constant,
// default timing values (also used by the destuff block and frame FSM) and a
// majority-vote helper used when triple sampling is enabled.
// -----------------------------------------------------------------------------
package can_pkg;

  typedef enum logic [1:0] {
    SEG_SYNC  = 2'd0,
    SEG_TSEG1 = 2'd1,
    SEG_TSEG2 = 2'd2
  } seg_t;

  localparam logic RECESSIVE = 1'b1;

  localparam int DEF_BRP        = 4;
  localparam int DEF_PROP_SEG   = 2;
  localparam int DEF_PHASE_SEG1 = 3;
  localparam int DEF_PHASE_SEG2 = 3;
  localparam int DEF_SJW        = 1;
  localparam int DEF_CNT_W      = 8;

  // Two-out-of-three vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/can_bit_timing_if.sv
// -----------------------------------------------------------------------------
// can_bit_timing_if
// Bundles the bit-timing stage signals.
//   rx           : raw CAN line (1 = recessive), driven by the bus side
//   hard_sync_en : hard-sync permission from the frame logic
//   sp           : one-clock sample-point pulse
//   rx_sampled   : bit value captured at sp
//   bit_start    : one-clock pulse on entry to SYNC
//   seg          : current bit segment
// master = environment / frame side, slave = the bit-timing block.
// -----------------------------------------------------------------------------
interface can_bit_timing_if;
  import can_pkg::*;

  logic rx;
  logic hard_sync_en;
  logic sp;
  logic rx_sampled;
  logic bit_start;
  seg_t seg;

  modport master (
    output rx,
    output hard_sync_en,
    input  sp,
    input  rx_sampled,
    input  bit_start,
    input  seg
  );

  modport slave (
    input  rx,
    input  hard_sync_en,
    output sp,
    output rx_sampled,
    output bit_start,
    output seg
  );

endinterface

// File: rtl/can_bit_timing_rx_sync.sv
// -----------------------------------------------------------------------------
// can_rx_sync
// Two-flop synchroniser for the asynchronous CAN rx line plus a
// recessive-to-dominant edge detector on the synchronised value.
// Ports:
//   clock    : system clock
//   reset    : asynchronous active-low reset (flops reset recessive)
//   rx       : raw bus line
//   rx_s     : synchronised rx
//   edge_det : high for one clock when rx_s goes 1 -> 0 (2 clocks after rx)
// -----------------------------------------------------------------------------
module can_rx_sync
  import can_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic edge_det
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchroniser chain and previous-value flop for edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_r <= RECESSIVE;
      sync_r <= RECESSIVE;
      prev_r <= RECESSIVE;
    end else begin
      meta_r <= rx;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign rx_s     = sync_r;
  assign edge_det = prev_r & ~sync_r;

endmodule

// File: rtl/can_bit_timing.sv
// -----------------------------------------------------------------------------
// can_bit_timing
// CAN bit-timing stage feeding the destuff block. Divides the clock into time
// quanta, walks SYNC / TSEG1 / TSEG2, applies hard sync and resync on
// recessive-to-dominant edges, and emits the sample point and sampled bit.
// Ports:
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : can_bit_timing_if.slave (rx, hard_sync_en in; sp, rx_sampled,
//           bit_start, seg out; all outputs registered)
// Optional feature: define CAN_TRIPLE_SAMPLE_EN to take the majority of the
// rx_s values seen at the ticks ending the last three TSEG1 quanta.
// -----------------------------------------------------------------------------
module can_bit_timing
  import can_pkg::*;
#(
  parameter int BRP        = DEF_BRP,
  parameter int PROP_SEG   = DEF_PROP_SEG,
  parameter int PHASE_SEG1 = DEF_PHASE_SEG1,
  parameter int PHASE_SEG2 = DEF_PHASE_SEG2,
  parameter int SJW        = DEF_SJW,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic            clock,
  input  logic            reset,
  can_bit_timing_if.slave bus
);

  localparam int TSEG1 = PROP_SEG + PHASE_SEG1;

  localparam logic [CNT_W-1:0] BRP_M1_C = CNT_W'(BRP - 1);
  localparam logic [CNT_W-1:0] TSEG1_C  = CNT_W'(TSEG1);
  localparam logic [CNT_W-1:0] PS2_C    = CNT_W'(PHASE_SEG2);
  localparam logic [CNT_W-1:0] SJW_C    = CNT_W'(SJW);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  // Elaboration-time parameter checks
  if (BRP < 2) begin : g_chk_brp
    $error("can_bit_timing: BRP must be >= 2");
  end
  if ((SJW < 1) || (SJW > 4)) begin : g_chk_sjw
    $error("can_bit_timing: SJW must be 1..4");
  end
  if (PHASE_SEG2 < (SJW + 1)) begin : g_chk_ps2
    $error("can_bit_timing: PHASE_SEG2 must be >= SJW+1");
  end
  if ((BRP > (1 << CNT_W)) || ((1 + TSEG1 + SJW + PHASE_SEG2) >= (1 << CNT_W))) begin : g_chk_width
    $error("can_bit_timing: timing parameters do not fit in CNT_W");
  end
`ifdef CAN_TRIPLE_SAMPLE_EN
  if (TSEG1 < 3) begin : g_chk_triple
    $error("can_bit_timing: triple sampling needs TSEG1 >= 3");
  end
`endif

  // Function: clamp a phase error to the resync jump width
  function automatic logic [CNT_W-1:0] clamp_sjw(input logic [CNT_W-1:0] e);
    return (e < SJW_C) ? e : SJW_C;
  endfunction

  logic rx_s;
  logic edge_det_s;

  can_rx_sync u_rx_sync (
    .clock    (clock),
    .reset    (reset),
    .rx       (bus.rx),
    .rx_s     (rx_s),
    .edge_det (edge_det_s)
  );

  logic [CNT_W-1:0] prescaler_r;
  logic [CNT_W-1:0] k_r;
  logic [CNT_W-1:0] ext_r;
  logic [CNT_W-1:0] short_r;
  seg_t             seg_r;
  logic             resync_done_r;
  logic             sp_r;
  logic             bit_start_r;
  logic             rx_sampled_r;

  logic             tick_s;
  logic             resync_ok_s;
  logic [CNT_W-1:0] end1_s;
  logic [CNT_W-1:0] prescaler_nxt_s;
  logic [CNT_W-1:0] k_nxt_s;
  logic [CNT_W-1:0] ext_nxt_s;
  logic [CNT_W-1:0] short_nxt_s;
  seg_t             seg_nxt_s;
  logic             done_nxt_s;
  logic             sp_nxt_s;
  logic             bit_start_nxt_s;
  logic             sample_bit_s;

  // Next-state computation for prescaler, segment, counters and resync state
  always_comb begin
    tick_s          = (prescaler_r == BRP_M1_C);
    end1_s          = TSEG1_C + ext_r;
    resync_ok_s     = edge_det_s && !bus.hard_sync_en && !resync_done_r &&
                      (rx_sampled_r == RECESSIVE);
    prescaler_nxt_s = tick_s ? '0 : (prescaler_r + ONE_C);
    seg_nxt_s       = seg_r;
    k_nxt_s         = k_r;
    ext_nxt_s       = ext_r;
    short_nxt_s     = short_r;
    done_nxt_s      = resync_done_r;

    if (edge_det_s && bus.hard_sync_en) begin
      // The edge cycle itself counts as quantum 0 of TSEG1, so the
      // prescaler resumes at 1.
      prescaler_nxt_s = ONE_C;
      seg_nxt_s       = SEG_TSEG1;
      k_nxt_s         = '0;
      ext_nxt_s       = '0;
      short_nxt_s     = '0;
      done_nxt_s      = 1'b1;
    end else begin
      case (seg_r)
        SEG_SYNC: begin
          if (resync_ok_s) begin
            done_nxt_s = 1'b1;
          end else begin
            done_nxt_s = resync_done_r;
          end
          if (tick_s) begin
            seg_nxt_s = SEG_TSEG1;
            k_nxt_s   = '0;
          end else begin
            k_nxt_s   = k_r;
          end
        end
        SEG_TSEG1: begin
          if (resync_ok_s) begin
            ext_nxt_s  = clamp_sjw(k_r + ONE_C);
            done_nxt_s = 1'b1;
          end else begin
            ext_nxt_s  = ext_r;
          end
          // The end test uses the current extension: an edge landing on the
          // sample-point cycle cannot move a sample point already issued.
          if (tick_s) begin
            if (k_r == (end1_s - ONE_C)) begin
              seg_nxt_s = SEG_TSEG2;
              k_nxt_s   = '0;
            end else begin
              k_nxt_s   = k_r + ONE_C;
            end
          end else begin
            k_nxt_s = k_r;
          end
        end
        SEG_TSEG2: begin
          if (resync_ok_s) begin
            short_nxt_s = clamp_sjw(PS2_C - k_r);
            done_nxt_s  = 1'b1;
          end else begin
            short_nxt_s = short_r;
          end
          // ">=" lets a shortening that lands at or before the current
          // quantum end TSEG2 at this tick.
          if (tick_s) begin
            if ((k_r + ONE_C) >= (PS2_C - short_nxt_s)) begin
              seg_nxt_s   = SEG_SYNC;
              k_nxt_s     = '0;
              ext_nxt_s   = '0;
              short_nxt_s = '0;
              done_nxt_s  = 1'b0;
            end else begin
              k_nxt_s     = k_r + ONE_C;
            end
          end else begin
            k_nxt_s = k_r;
          end
        end
        default: begin
          seg_nxt_s   = SEG_SYNC;
          k_nxt_s     = '0;
          ext_nxt_s   = '0;
          short_nxt_s = '0;
          done_nxt_s  = 1'b0;
        end
      endcase
    end

    // Outputs are registered one cycle ahead so that sp coincides with the
    // tick ending TSEG1 and bit_start with the first SYNC cycle.
    sp_nxt_s        = (seg_nxt_s == SEG_TSEG1) && (prescaler_nxt_s == BRP_M1_C) &&
                      (k_nxt_s == (TSEG1_C + ext_nxt_s - ONE_C));
    bit_start_nxt_s = (seg_nxt_s == SEG_SYNC) && (seg_r != SEG_SYNC);
  end

`ifdef CAN_TRIPLE_SAMPLE_EN
  logic [1:0] samp_r;

  // History of rx_s at TSEG1 tick boundaries; the two newest precede sp
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      samp_r <= {2{RECESSIVE}};
    end else if (tick_s && (seg_r == SEG_TSEG1)) begin
      samp_r <= {samp_r[0], rx_s};
    end else begin
      samp_r <= samp_r;
    end
  end

  assign sample_bit_s = maj3(samp_r[1], samp_r[0], rx_s);
`else
  assign sample_bit_s = rx_s;
`endif

  // Timing state and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler_r   <= '0;
      k_r           <= '0;
      ext_r         <= '0;
      short_r       <= '0;
      seg_r         <= SEG_SYNC;
      resync_done_r <= 1'b0;
      sp_r          <= 1'b0;
      bit_start_r   <= 1'b0;
      rx_sampled_r  <= RECESSIVE;
    end else begin
      prescaler_r   <= prescaler_nxt_s;
      k_r           <= k_nxt_s;
      ext_r         <= ext_nxt_s;
      short_r       <= short_nxt_s;
      seg_r         <= seg_nxt_s;
      resync_done_r <= done_nxt_s;
      sp_r          <= sp_nxt_s;
      bit_start_r   <= bit_start_nxt_s;
      if (sp_r) begin
        rx_sampled_r <= sample_bit_s;
      end else begin
        rx_sampled_r <= rx_sampled_r;
      end
    end
  end

  assign bus.sp         = sp_r;
  assign bus.bit_start  = bit_start_r;
  assign bus.rx_sampled = rx_sampled_r;
  assign bus.seg        = seg_r;

endmodule
